// File: rtl/multdiv_pkg.sv
// Shared definitions for the multdiv issue sequencer.
//   md_state_e             : sequencer FSM states
//   OP_MUL / OP_DIV        : encoding of the latched operation select
//   TIMEOUT_CYCLES_DEFAULT : default watchdog limit for WAIT
package multdiv_pkg;

  localparam int TIMEOUT_CYCLES_DEFAULT = 64;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } md_state_e;

endpackage

// File: rtl/multdiv_issue_ctrl_if.sv
// Bundle of the execute-stage issue port, the multdiv unit port and the
// write-back port of multdiv_issue_ctrl.
//   slave  : seen by the sequencer (drives ready/stall/start/write-back)
//   master : seen by the surrounding pipeline and multdiv unit
interface multdiv_issue_ctrl_if;
  logic        issue_valid;
  logic        issue_is_div;
  logic [4:0]  issue_rd;
  logic [31:0] issue_a;
  logic [31:0] issue_b;
  logic        issue_ready;
  logic        flush;
  logic        stall;
  logic [31:0] md_operandA;
  logic [31:0] md_operandB;
  logic        md_ctrl_MULT;
  logic        md_ctrl_DIV;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_resultRDY;
  logic        md_running;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_exception;
  logic        timeout_err;

  modport slave (
    input  issue_valid, issue_is_div, issue_rd, issue_a, issue_b, flush,
           md_result, md_exception, md_resultRDY, md_running,
    output issue_ready, stall, md_operandA, md_operandB, md_ctrl_MULT,
           md_ctrl_DIV, wb_valid, wb_rd, wb_data, wb_exception, timeout_err
  );

  modport master (
    output issue_valid, issue_is_div, issue_rd, issue_a, issue_b, flush,
           md_result, md_exception, md_resultRDY, md_running,
    input  issue_ready, stall, md_operandA, md_operandB, md_ctrl_MULT,
           md_ctrl_DIV, wb_valid, wb_rd, wb_data, wb_exception, timeout_err
  );
endinterface

// File: rtl/md_watchdog.sv
// Cycle counter guarding the WAIT state of the multdiv sequencer.
//   clock, reset_n : clock and synchronous active-low reset
//   clear          : restart counting from zero
//   enable         : count one cycle
//   expire         : counter has reached TIMEOUT_CYCLES-1
module md_watchdog #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [CNT_W-1:0] cnt_r;

  // Cycle counter; the owner leaves WAIT on expiry so it never wraps.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (enable) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expire = (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Sequencer between the RV32 execute stage and the shared iterative multdiv
// unit: accepts one MUL/DIV, pulses the unit's start input, stalls the
// pipeline while waiting, then issues a one-cycle write-back. Handles flush,
// a unit still busy after reset, and a watchdog timeout.
//   clock, reset_n : clock and synchronous active-low reset
//   bus            : issue, multdiv and write-back signals (slave side)
module multdiv_issue_ctrl
  import multdiv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  multdiv_issue_ctrl_if.slave  bus
);

  md_state_e   state_r, state_nxt_s;
  logic [31:0] op_a_r, op_b_r;
  logic [4:0]  rd_r;
  logic        is_div_r;
  logic [4:0]  wb_rd_r;
  logic [31:0] wb_data_r;
  logic        wb_exc_r;
  logic        timeout_err_r;
  logic        timed_out_r;

  logic issue_ready_s, accept_s, capture_s, timeout_s;
  logic wd_clear_s, wd_en_s, wd_expire_s;

  md_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_watchdog (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (wd_clear_s),
    .enable  (wd_en_s),
    .expire  (wd_expire_s)
  );

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_nxt_s   = state_r;
    issue_ready_s = 1'b0;
    accept_s      = 1'b0;
    capture_s     = 1'b0;
    timeout_s     = 1'b0;
    wd_clear_s    = 1'b0;
    wd_en_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        issue_ready_s = !bus.md_running && !bus.flush;
        // A unit still busy here was started before a reset; let it finish.
        if (bus.md_running) begin
          state_nxt_s = ST_DRAIN;
        end else if (bus.issue_valid && issue_ready_s) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        wd_clear_s = 1'b1;
        if (bus.flush) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_WAIT: begin
        wd_en_s = 1'b1;
        // A result arriving with a flush is dropped; the unit is already idle.
        if (bus.flush && bus.md_resultRDY) begin
          state_nxt_s = ST_IDLE;
        end else if (bus.md_resultRDY) begin
          capture_s   = 1'b1;
          state_nxt_s = ST_DONE;
        end else if (bus.flush) begin
          state_nxt_s = ST_DRAIN;
        end else if (wd_expire_s) begin
          timeout_s   = 1'b1;
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        if (timed_out_r) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (bus.md_resultRDY || !bus.md_running) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Operand latch, held from acceptance until the next acceptance.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      op_a_r   <= 32'h0000_0000;
      op_b_r   <= 32'h0000_0000;
      rd_r     <= 5'd0;
      is_div_r <= OP_MUL;
    end else if (accept_s) begin
      op_a_r   <= bus.issue_a;
      op_b_r   <= bus.issue_b;
      rd_r     <= bus.issue_rd;
      is_div_r <= bus.issue_is_div;
    end else begin
      op_a_r   <= op_a_r;
      op_b_r   <= op_b_r;
      rd_r     <= rd_r;
      is_div_r <= is_div_r;
    end
  end

  // Write-back registers: unit result, or a forced error on timeout.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wb_rd_r   <= 5'd0;
      wb_data_r <= 32'h0000_0000;
      wb_exc_r  <= 1'b0;
    end else if (capture_s) begin
      wb_rd_r   <= rd_r;
      wb_data_r <= bus.md_result;
      wb_exc_r  <= bus.md_exception;
    end else if (timeout_s) begin
      wb_rd_r   <= rd_r;
      wb_data_r <= 32'h0000_0000;
      wb_exc_r  <= 1'b1;
    end else begin
      wb_rd_r   <= wb_rd_r;
      wb_data_r <= wb_data_r;
      wb_exc_r  <= wb_exc_r;
    end
  end

  // Sticky timeout flag plus the per-op marker that routes DONE to DRAIN.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      timeout_err_r <= 1'b0;
      timed_out_r   <= 1'b0;
    end else if (timeout_s) begin
      timeout_err_r <= 1'b1;
      timed_out_r   <= 1'b1;
    end else if (state_r == ST_DONE) begin
      timeout_err_r <= timeout_err_r;
      timed_out_r   <= 1'b0;
    end else begin
      timeout_err_r <= timeout_err_r;
      timed_out_r   <= timed_out_r;
    end
  end

  assign bus.issue_ready  = issue_ready_s;
  assign bus.stall        = (state_r != ST_IDLE) || (bus.issue_valid && !issue_ready_s);
  assign bus.md_operandA  = op_a_r;
  assign bus.md_operandB  = op_b_r;
  assign bus.md_ctrl_MULT = (state_r == ST_START) && (is_div_r == OP_MUL);
  assign bus.md_ctrl_DIV  = (state_r == ST_START) && (is_div_r == OP_DIV);
  assign bus.wb_valid     = (state_r == ST_DONE) && !bus.flush;
  assign bus.wb_rd        = wb_rd_r;
  assign bus.wb_data      = wb_data_r;
  assign bus.wb_exception = wb_exc_r;
  assign bus.timeout_err  = timeout_err_r;

endmodule

// File: doc/multdiv_issue_ctrl.md
Name: multdiv_issue_ctrl

Overview:
Sequencer between the RV32 execute stage and the shared iterative multdiv unit. It accepts one MUL or DIV request at a time and latches the operands and destination register. It sends a one-cycle start pulse, stalls the pipeline until the unit reports ready, then presents a one-cycle write-back. It also handles flush, reset while the unit is mid-operation, and a watchdog timeout.

Parameters:
TIMEOUT_CYCLES, 64, max cycles in WAIT before forced completion; must exceed the worst-case multdiv latency.
CNT_W, $clog2(TIMEOUT_CYCLES+1), watchdog counter width.

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  synchronous, active-low reset
issue_valid  input  1  execute stage presents a mult/div op
issue_is_div  input  1  0 = MUL, 1 = DIV
issue_rd  input  5  destination register
issue_a  input  32  operand A
issue_b  input  32  operand B
issue_ready  output  1  request accepted this cycle when issue_valid is also high
flush  input  1  kill the in-flight op
stall  output  1  freeze upstream pipeline
md_operandA  output  32  to multdiv data_operandA
md_operandB  output  32  to multdiv data_operandB
md_ctrl_MULT  output  1  start pulse to multdiv
md_ctrl_DIV  output  1  start pulse to multdiv
md_result  input  32  multdiv data_result
md_exception  input  1  multdiv data_exception
md_resultRDY  input  1  multdiv data_resultRDY
md_running  input  1  multdiv running
wb_valid  output  1  one-cycle write-back strobe
wb_rd  output  5  write-back register
wb_data  output  32  write-back value
wb_exception  output  1  overflow, div-by-zero or timeout
timeout_err  output  1  sticky watchdog flag

Behaviour:
- Reset (reset_n=0 at an edge): state=IDLE, all registers and outputs 0, timeout_err cleared. The multdiv unit itself has no reset.
- FSM states: IDLE, START, WAIT, DONE, DRAIN.
- IDLE:
  - issue_ready = !md_running && !flush.
  - md_running=1 → DRAIN. This covers reset arriving mid-operation.
  - issue_valid && issue_ready → latch a, b, rd, is_div; go to START.
- START (1 cycle): md_ctrl_MULT = !is_div, md_ctrl_DIV = is_div, both combinational from state. flush → DRAIN; otherwise → WAIT with the watchdog counter cleared.
- WAIT:
  - md_resultRDY → capture result and exception into wb registers; go to DONE.
  - flush → DRAIN. If flush and md_resultRDY occur together, discard the result and go to IDLE.
  - counter == TIMEOUT_CYCLES-1 → DONE with wb_data=0, wb_exception=1, timeout_err set; then → DRAIN instead of IDLE.
- DONE (1 cycle): wb_valid = !flush; wb_rd, wb_data and wb_exception are held stable. Go to IDLE, or to DRAIN after a timeout.
- DRAIN: no write-back. Exit to IDLE when md_resultRDY=1, or when md_running=0 with md_resultRDY=0.
- stall = (state != IDLE) || (issue_valid && !issue_ready).
- md_operandA and md_operandB come from the latch registers and stay stable from START until leaving WAIT or DRAIN.
- md_resultRDY is ignored in IDLE, START and DONE.
- Start pulses are never asserted outside START, and never both high.
- Nominal latency: accept edge → START → WAIT(N) → DONE. wb_valid appears N+2 cycles after acceptance.
- rd=0 is executed normally and wb_valid pulses; the register file discards x0 writes.

Decomposition:
- Shared package multdiv_pkg holds:
  - the state enum (IDLE/START/WAIT/DONE/DRAIN);
  - OP_MUL=1'b0 and OP_DIV=1'b1;
  - TIMEOUT_CYCLES default.
- One natural sub-module: md_watchdog (counter with clear, enable and expire output). The rest stays flat.

Test Plan:
- MUL 7×(-3), rd=5, with the unit ready after 32 cycles → one start pulse on MULT only; stall high throughout; wb_valid for exactly 1 cycle with wb_rd=5, wb_data=0xFFFFFFEB, wb_exception=0.
- DIV 100/0 → DIV pulse only; wb_exception=1 forwarded from md_exception; a second issue is not accepted until DONE → IDLE.
- Flush 5 cycles into WAIT → FSM enters DRAIN; no wb_valid when md_resultRDY arrives; issue_ready returns 1 the cycle after.
- flush and md_resultRDY in the same WAIT cycle → no write-back; IDLE next cycle.
- reset_n low for 1 cycle mid-division with md_running=1 → IDLE, then DRAIN; issue_ready=0 until the unit finishes; no spurious wb_valid.
- TIMEOUT_CYCLES=8 with the model never asserting ready → DONE at cycle 8 with wb_data=0, wb_exception=1; timeout_err stays 1 until reset.
